// File: rtl/sign_ext_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sign_ext_pkg : skid state encoding and the shared extension function  |
// | Revision     : 1.0                                                    |
// +-----------------------------------------------------------------------+
package sign_ext_pkg;

  localparam int EXT_MAX = 64;
  typedef logic [EXT_MAX-1:0] ext_t;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_t;

  // Callers truncate the result to their own output width; w must be 1..EXT_MAX-1.
  function automatic ext_t ext_field(input ext_t data, input int w, input logic sgn);
    ext_t top_bit;
    ext_t mask;
    top_bit = ext_t'(1) << (w - 1);
    mask    = (top_bit << 1) - ext_t'(1);
    if (sgn && ((data & top_bit) != '0))
      return (data & mask) | ~mask;
    return data & mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sign_ext_skid.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sign_ext_skid : two-entry skid buffer, registered ready and valid     |
// | Revision      : 1.0                                                   |
// +-----------------------------------------------------------------------+
module sign_ext_skid #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
);
  import sign_ext_pkg::*;

  skid_state_t      state;
  logic [WIDTH-1:0] skid_data;
  logic             in_xfer;
  logic             out_xfer;

  assign in_xfer  = s_valid && s_ready;
  assign out_xfer = m_valid && m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SKID_EMPTY;
      m_valid   <= 1'b0;
      s_ready   <= 1'b1;
      m_data    <= '0;
      skid_data <= '0;
    end else begin
      case (state)
        SKID_EMPTY: begin
          if (in_xfer) begin
            m_data  <= s_data;
            m_valid <= 1'b1;
            state   <= SKID_ONE;
          end
        end
        SKID_ONE: begin
          if (in_xfer && out_xfer) begin
            m_data <= s_data;
          end else if (in_xfer) begin
            // Output stalled: park the beat and drop ready in the same edge.
            skid_data <= s_data;
            s_ready   <= 1'b0;
            state     <= SKID_FULL;
          end else if (out_xfer) begin
            m_valid <= 1'b0;
            state   <= SKID_EMPTY;
          end
        end
        SKID_FULL: begin
          if (out_xfer) begin
            m_data  <= skid_data;
            s_ready <= 1'b1;
            state   <= SKID_ONE;
          end
        end
        default: begin
          state   <= SKID_EMPTY;
          m_valid <= 1'b0;
          s_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/sign_ext_stream.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sign_ext_stream : handshaked N->M sign/zero extender with skid buffer |
// | Option          : SIGN_EXT_ERR_EN adds o_err for illegal widths       |
// | Revision        : 1.0                                                 |
// +-----------------------------------------------------------------------+
module sign_ext_stream #(
  parameter int N  = 12,
  parameter int M  = 32,
  parameter int WW = $clog2(N + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [N-1:0]  i_data,
  input  logic [WW-1:0] i_src_w,
  input  logic          i_signed,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [M-1:0]  o_data
`ifdef SIGN_EXT_ERR_EN
  ,
  output logic          o_err
`endif
);
  import sign_ext_pkg::*;

  logic          illegal;
  logic [WW-1:0] eff_w;
  logic [M-1:0]  ext_word;

  assign illegal  = (i_src_w == '0) || (int'(i_src_w) > N);
  assign eff_w    = illegal ? WW'(N) : i_src_w;
  assign ext_word = M'(ext_field(ext_t'(i_data), int'(eff_w), i_signed));

`ifdef SIGN_EXT_ERR_EN
  localparam int DW = M + 1;
  logic [DW-1:0] in_word;
  logic [DW-1:0] out_word;

  // Illegal beats still flow in order; they carry a zero word and the err bit.
  assign in_word = illegal ? {1'b1, {M{1'b0}}} : {1'b0, ext_word};
  assign o_data  = out_word[M-1:0];
  assign o_err   = o_valid & out_word[M];
`else
  localparam int DW = M;
  logic [DW-1:0] in_word;
  logic [DW-1:0] out_word;

  assign in_word = ext_word;
  assign o_data  = out_word;
`endif

  sign_ext_skid #(
    .WIDTH(DW)
  ) u_skid (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .s_valid(i_valid),
    .s_ready(o_ready),
    .s_data (in_word),
    .m_valid(o_valid),
    .m_ready(i_ready),
    .m_data (out_word)
  );

endmodule
`default_nettype wire

// File: tb/tb_sign_ext_stream.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_sign_ext_stream : scoreboard bench for sign_ext_stream (N=12,M=32) |
// | Revision           : 1.0                                              |
// +-----------------------------------------------------------------------+
module tb_sign_ext_stream;
  import sign_ext_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [11:0] i_data;
  logic [3:0]  i_src_w;
  logic        i_signed;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_data;
  logic        err_s;

  int n_cmp = 0;
  int n_err = 0;
  logic [32:0] exp_q[$];
  logic [32:0] obs_q[$];
  logic [32:0] got;
  logic [32:0] want;

  sign_ext_stream #(.N(12), .M(32)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (i_data),
    .i_src_w (i_src_w),
    .i_signed(i_signed),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (o_data)
`ifdef SIGN_EXT_ERR_EN
    ,
    .o_err   (err_s)
`endif
  );
`ifndef SIGN_EXT_ERR_EN
  assign err_s = 1'b0;
`endif

  always #5 i_clk = ~i_clk;

  function automatic logic [32:0] model(input logic [11:0] d, input logic [3:0] w, input logic s);
    int wi;
    logic [31:0] r;
    wi = int'(w);
`ifdef SIGN_EXT_ERR_EN
    if (wi == 0 || wi > 12) return {1'b1, 32'h0};
`else
    if (wi == 0 || wi > 12) wi = 12;
`endif
    r = 32'(ext_field(ext_t'(d), wi, s));
    return {1'b0, r};
  endfunction

  // Called just after a falling edge with inputs settled; records the transfers
  // of the coming rising edge and returns at the next falling edge.
  task automatic tick();
    if (i_valid && o_ready) exp_q.push_back(model(i_data, i_src_w, i_signed));
    if (o_valid && i_ready) obs_q.push_back({err_s, o_data});
    @(negedge i_clk);
  endtask

  task automatic beat(input logic [11:0] d, input logic [3:0] w, input logic s);
    i_valid = 1'b1; i_data = d; i_src_w = w; i_signed = s;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    i_data = '0; i_src_w = 4'd12; i_signed = 1'b0;
    @(negedge i_clk);
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b want=0", o_valid); end
    n_cmp++; if (o_data !== 32'h0) begin n_err++; $display("FAIL reset_data got=%h want=0", o_data); end
    n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b want=1", o_ready); end
    n_cmp++; if (err_s !== 1'b0) begin n_err++; $display("FAIL reset_err got=%b want=0", err_s); end
    i_rst_n = 1'b1;
    @(negedge i_clk);
  endtask

  task automatic test_streaming();
    logic [11:0] d;
    i_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      d = 12'hFF6 + 12'(k);
      beat(d, 4'd12, 1'b1);
      tick();
      n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL stream_ready k=%0d got=%b want=1", k, o_ready); end
      n_cmp++; if (o_valid !== 1'b1 || o_data !== {{20{d[11]}}, d}) begin
        n_err++; $display("FAIL stream_data k=%0d got=%b/%h want=1/%h", k, o_valid, o_data, {{20{d[11]}}, d});
      end
    end
    i_valid = 1'b0;
    tick();
    while (obs_q.size() > 0) begin
      got = obs_q.pop_front(); want = (exp_q.size() > 0) ? exp_q.pop_front() : 33'h1_DEADBEEF;
      n_cmp++; if (got !== want) begin n_err++; $display("FAIL stream_sb got=%h want=%h", got, want); end
    end
  endtask

  task automatic test_variable_width();
    i_ready = 1'b1;
    beat(12'hF1F, 4'd5, 1'b1);
    tick();
    n_cmp++; if (o_data !== 32'hFFFFFFFF) begin n_err++; $display("FAIL varw_signed got=%h want=ffffffff", o_data); end
    beat(12'hF1F, 4'd5, 1'b0);
    tick();
    n_cmp++; if (o_data !== 32'h0000001F) begin n_err++; $display("FAIL varw_unsigned got=%h want=0000001f", o_data); end
    beat(12'h0A5, 4'd1, 1'b1);
    tick();
    n_cmp++; if (o_data !== 32'hFFFFFFFF) begin n_err++; $display("FAIL varw_w1 got=%h want=ffffffff", o_data); end
    i_valid = 1'b0;
    tick();
    while (obs_q.size() > 0) begin
      got = obs_q.pop_front(); want = (exp_q.size() > 0) ? exp_q.pop_front() : 33'h1_DEADBEEF;
      n_cmp++; if (got !== want) begin n_err++; $display("FAIL varw_sb got=%h want=%h", got, want); end
    end
  endtask

  task automatic test_illegal_width();
    i_ready = 1'b1;
    beat(12'h800, 4'd13, 1'b1);
    tick();
`ifdef SIGN_EXT_ERR_EN
    n_cmp++; if (o_data !== 32'h0 || err_s !== 1'b1) begin
      n_err++; $display("FAIL illegal_w13 got=%h/%b want=00000000/1", o_data, err_s);
    end
`else
    n_cmp++; if (o_data !== 32'hFFFFF800) begin n_err++; $display("FAIL illegal_w13 got=%h want=fffff800", o_data); end
`endif
    beat(12'h7FF, 4'd0, 1'b1);
    tick();
    i_valid = 1'b0;
    tick();
    while (obs_q.size() > 0) begin
      got = obs_q.pop_front(); want = (exp_q.size() > 0) ? exp_q.pop_front() : 33'h1_DEADBEEF;
      n_cmp++; if (got !== want) begin n_err++; $display("FAIL illegal_sb got=%h want=%h", got, want); end
    end
  endtask

  task automatic test_backpressure();
    i_ready = 1'b0;
    beat(12'h001, 4'd12, 1'b0);
    tick();
    n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_one got=%b want=1", o_ready); end
    beat(12'h002, 4'd12, 1'b0);
    tick();
    n_cmp++; if (o_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_full got=%b want=0", o_ready); end
    beat(12'h003, 4'd12, 1'b0);
    tick();
    n_cmp++; if (o_ready !== 1'b0 || o_data !== 32'h1) begin
      n_err++; $display("FAIL bp_hold got=%b/%h want=0/00000001", o_ready, o_data);
    end
    i_ready = 1'b1;
    tick();
    n_cmp++; if (o_ready !== 1'b1 || o_data !== 32'h2) begin
      n_err++; $display("FAIL bp_first_drain got=%b/%h want=1/00000002", o_ready, o_data);
    end
    tick();
    i_valid = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    n_cmp++; if (exp_q.size() != 3 || obs_q.size() != 3) begin
      n_err++; $display("FAIL bp_count got=%0d/%0d want=3/3", exp_q.size(), obs_q.size());
    end
    while (obs_q.size() > 0) begin
      got = obs_q.pop_front(); want = (exp_q.size() > 0) ? exp_q.pop_front() : 33'h1_DEADBEEF;
      n_cmp++; if (got !== want) begin n_err++; $display("FAIL bp_sb got=%h want=%h", got, want); end
    end
  endtask

  task automatic test_reset_full();
    i_ready = 1'b0;
    beat(12'h111, 4'd12, 1'b0);
    tick();
    beat(12'h222, 4'd12, 1'b0);
    tick();
    i_valid = 1'b0;
    #2 i_rst_n = 1'b0;
    #1;
    n_cmp++; if (o_valid !== 1'b0 || o_data !== 32'h0 || o_ready !== 1'b1) begin
      n_err++; $display("FAIL rstfull got=%b/%h/%b want=0/00000000/1", o_valid, o_data, o_ready);
    end
    exp_q.delete();
    obs_q.delete();
    #1 i_rst_n = 1'b1;
    i_ready = 1'b1;
    beat(12'h0AB, 4'd12, 1'b0);
    tick();
    n_cmp++; if (o_valid !== 1'b1 || o_data !== 32'h0AB) begin
      n_err++; $display("FAIL rstfull_next got=%b/%h want=1/000000ab", o_valid, o_data);
    end
    i_valid = 1'b0;
    tick();
    while (obs_q.size() > 0) begin
      got = obs_q.pop_front(); want = (exp_q.size() > 0) ? exp_q.pop_front() : 33'h1_DEADBEEF;
      n_cmp++; if (got !== want) begin n_err++; $display("FAIL rstfull_sb got=%h want=%h", got, want); end
    end
  endtask

  task automatic test_random_soak();
    for (int c = 0; c < 10000; c++) begin
      i_valid  = ($urandom_range(0, 3) != 0);
      i_ready  = ($urandom_range(0, 3) != 0);
      i_data   = 12'($urandom());
      i_src_w  = 4'($urandom_range(0, 15));
      i_signed = 1'($urandom_range(0, 1));
      tick();
      while (obs_q.size() > 0) begin
        got = obs_q.pop_front(); want = (exp_q.size() > 0) ? exp_q.pop_front() : 33'h1_DEADBEEF;
        n_cmp++; if (got !== want) begin n_err++; $display("FAIL soak_sb cyc=%0d got=%h want=%h", c, got, want); end
      end
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    while (obs_q.size() > 0) begin
      got = obs_q.pop_front(); want = (exp_q.size() > 0) ? exp_q.pop_front() : 33'h1_DEADBEEF;
      n_cmp++; if (got !== want) begin n_err++; $display("FAIL soak_drain got=%h want=%h", got, want); end
    end
    n_cmp++; if (exp_q.size() != 0 || o_valid !== 1'b0) begin
      n_err++; $display("FAIL soak_lost got=%0d/%b want=0/0", exp_q.size(), o_valid);
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_variable_width();
    test_illegal_width();
    test_backpressure();
    test_reset_full();
    test_random_soak();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sign_ext_stream.md
# sign_ext_stream

Registered, handshaked sign/zero extender, the next generation of our combinational N→M sign extender. Each beat carries an N-bit field, a per-beat source width and an extension mode, and produces an M-bit extended word. It sits between the instruction decoder and the operand pipeline. A two-entry skid buffer gives full throughput with a registered upstream ready.

## Interface
- `N`, default 12: maximum source field width, 1 ≤ N < M.
- `M`, default 32: output width.
- `WW`, default $clog2(N+1): width of the source-width select.
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_valid`  in  1  upstream beat valid.
- `o_ready`  out  1  upstream ready, driven from a register.
- `i_data`  in  N  source field; bits at index W and above are ignored.
- `i_src_w`  in  WW  effective source width W (legal range 1..N).
- `i_signed`  in  1  1 = sign-extend from bit W-1; 0 = zero-extend.
- `o_valid`  out  1  downstream beat valid.
- `i_ready`  in  1  downstream ready.
- `o_data`  out  M  extended word.
- `o_err`  out  1  illegal width flag; present only with `SIGN_EXT_ERR_EN`.

## Operation
- A beat transfers when valid and ready are both high on a rising edge, on either side.
- Result per beat:
  - o_data[W-1:0] = i_data[W-1:0].
  - o_data[M-1:W] = all copies of i_data[W-1] if i_signed is 1, otherwise all zeros.
- Extension is computed on input and stored already extended. The buffer holds M bits plus, with the macro, one err bit per entry.
- The skid buffer has states EMPTY, ONE and FULL. Occupancy is 0, 1 and 2; the output register is entry 0 and the skid register is entry 1.
  - EMPTY → ONE on input transfer.
  - ONE → EMPTY on output transfer with no input transfer.
  - ONE → FULL on input transfer while the output stalls.
  - ONE stays ONE when both transfer in the same cycle.
  - FULL → ONE on output transfer; the skid entry moves to the output register.
  - FULL never accepts input.
- o_ready = (state != FULL), registered.
- Ordering is strict FIFO; no beat is dropped or duplicated.
- o_data holds its value while o_valid is high and i_ready is low.
- Reset, asserted at any time including mid-transfer: buffered beats are discarded and state goes to EMPTY. Reset values:
  - o_valid = 0
  - o_data = 0
  - o_ready = 1
  - o_err = 0

## Timing
- Latency is 1 cycle: a beat accepted at edge k is presented with o_valid high after edge k, if the buffer was EMPTY or its output drained at k.
- Throughput is 1 beat per cycle while i_ready stays high.
- o_ready falls one cycle after the buffer fills. This is why the skid entry exists.
- o_ready rises the cycle after the first output transfer out of FULL.
- There is no combinational path from i_ready to o_ready, or from the input data/control to any output.

## Configuration
- `SIGN_EXT_ERR_EN` defined:
  - W = 0 or W > N marks the beat illegal.
  - An illegal beat is still accepted and delivered in order, with o_data = 0 and o_err = 1.
  - o_err is qualified by o_valid.
- `SIGN_EXT_ERR_EN` undefined:
  - No o_err port.
  - An illegal W is clamped to N.
  - No other behavioural difference.

## Structure
- Package `sign_ext_pkg`:
  - skid state encoding (EMPTY/ONE/FULL);
  - function `ext_field(data, w, signed)` returning the M-bit result, shared with the bench reference model.
- Sub-module `sign_ext_skid`: generic 2-entry, WIDTH-parameterised skid buffer with valid/ready on both sides. The top level is the extender datapath feeding it.

## Test plan
- **Streaming:** N=12, M=32, i_ready held 1, i_signed=1, W=12, i_data = 12'hFF6 (-10) through 12'h005 on consecutive cycles → o_data = 32'hFFFFFFF6 … 32'h00000005, one per cycle, 1-cycle latency, o_ready never low.
- **Variable width:** W=5, i_data = 12'hF1F.
  - i_signed=1 → o_data = 32'hFFFFFFFF.
  - i_signed=0 → o_data = 32'h0000001F.
- **Backpressure:** i_ready=0 with three beats offered → two accepted, o_ready=0 from the cycle after the second. Then i_ready=1 → beats emerge in order, o_ready back to 1 one cycle after the first drain, third beat accepted.
- **Reset in FULL:** i_rst_n pulsed low mid-cycle → immediately o_valid=0, o_data=0, o_ready=1. The next accepted beat is the first one out.
- **Illegal width, with `SIGN_EXT_ERR_EN`:** W=13 → o_data=0, o_err=1. Without the macro: W=13 on 12'h800 with i_signed=1 → 32'hFFFFF800.
- **Randomised soak:** random valid/ready/width/mode over 10k cycles, checked against `ext_field` with a scoreboard → zero mismatches, zero lost or duplicated beats.
